aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl.sv | 132 +++++++++++++
 tb/tb_aes_round_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// AES round controller.
// Sequences an external single-round datapath over NR rounds: the initial
// AddRoundKey on accept, then one round per clock, the last round without
// MixColumns. Key schedule and round function live outside this block.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready and out_valid come straight from flops, so neither
// depends combinationally on any input; in particular out_ready never
// reaches in_ready in the same cycle.
module aes_round_ctrl #(
    // Number of cipher rounds, legal range 2..15 (round_cnt is 4 bits wide).
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_in,
    output logic [127:0] rf_state,
    output logic         rf_last,
    input  logic [127:0] rf_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_e;

    fsm_e         fsm_q,       fsm_d;
    logic [3:0]   round_cnt_q, round_cnt_d;
    logic [127:0] state_q,     state_d;

    // Outputs are registered: their next values are decoded from the next
    // FSM state so they line up with fsm_q/round_cnt_q every cycle.
    logic         in_ready_q,  in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q,      busy_d;
    logic         rf_last_q,   rf_last_d;
    logic [3:0]   rk_idx_q,    rk_idx_d;

    // Next-state, round counter, state register and registered-output decode.
    always_comb begin
        fsm_d       = fsm_q;
        round_cnt_d = round_cnt_q;
        state_d     = state_q;

        case (fsm_q)
            ST_IDLE: begin
                // rk_idx is 0 here, so rk_in is the whitening key.
                if (in_valid) begin
                    state_d     = in_data ^ rk_in;
                    round_cnt_d = 4'd1;
                    fsm_d       = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = rf_result ^ rk_in;
                if (round_cnt_q == NR_L) begin
                    // Counter parks at NR; it is cleared when leaving DONE.
                    fsm_d = ST_DONE;
                end else begin
                    round_cnt_d = round_cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                // Ciphertext held until taken; no accept in this same cycle.
                if (out_ready) begin
                    fsm_d       = ST_IDLE;
                    round_cnt_d = 4'd0;
                end
            end
            default: begin
                fsm_d       = ST_IDLE;
                round_cnt_d = 4'd0;
            end
        endcase

        in_ready_d  = (fsm_d == ST_IDLE);
        out_valid_d = (fsm_d == ST_DONE);
        busy_d      = (fsm_d == ST_RUN);
        rf_last_d   = (fsm_d == ST_RUN) && (round_cnt_d == NR_L);
        rk_idx_d    = (fsm_d == ST_RUN) ? round_cnt_d : 4'd0;
    end

    // Single sequential block: FSM, counter, state register and output flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q       <= ST_IDLE;
            round_cnt_q <= 4'd0;
            state_q     <= 128'h0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rf_last_q   <= 1'b0;
            rk_idx_q    <= 4'd0;
        end else begin
            fsm_q       <= fsm_d;
            round_cnt_q <= round_cnt_d;
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            rf_last_q   <= rf_last_d;
            rk_idx_q    <= rk_idx_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign rf_last   = rf_last_q;
    assign rk_idx    = rk_idx_q;
    assign rf_state  = state_q;
    assign out_data  = state_q;

    // Invariants: the counter never passes NR, and exactly one of the three
    // state-indicating outputs is high.
    a_cnt_bound : assert property (@(posedge clk) disable iff (!rst_n)
        round_cnt_q <= NR_L);
    a_state_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot({in_ready_q, busy_q, out_valid_q}));

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl (NR = 10).
// Provides either a real AES-128 key schedule and round function or identity
// models (rk_in = 0, rf_result = rf_state), selected by 'mode'.
// Inputs are driven and outputs sampled on the falling edge.
module tb_aes_round_ctrl;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] IDV  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] IDV2 = 128'hdeadbeefcafef00d0badc0de12345678;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_ready, rf_last, out_valid, busy;
    logic [3:0]   rk_idx;
    logic [127:0] rk_in, rf_state, rf_result, out_data, rf_aes;

    logic         mode = 1'b0;
    logic [7:0]   sbox [0:255];
    logic [127:0] rk_tab [0:15];

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    aes_round_ctrl #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk_in     (rk_in),
        .rf_state  (rf_state),
        .rf_last   (rf_last),
        .rf_result (rf_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- AES reference models ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                      ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk_tab[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
        logic [7:0]   b [0:15];
        logic [7:0]   t [0:15];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                t[4*c+rr] = b[4*((c+rr)%4)+rr];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
        return r;
    endfunction

    assign rf_aes    = aes_round(rf_state, rf_last);
    assign rf_result = mode ? rf_aes : rf_state;
    assign rk_in     = mode ? rk_tab[rk_idx] : 128'h0;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_data = rnd128(); out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (rf_last !== 1'b0) begin n_err++; $display("FAIL reset_rf_last: got %b want 0", rf_last); end
        n_vec++; if (rk_idx !== 4'd0) begin n_err++; $display("FAIL reset_rk_idx: got %0d want 0", rk_idx); end
        n_vec++; if (out_data !== 128'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_vec++; if (rf_state !== 128'h0) begin n_err++; $display("FAIL reset_rf_state: got %h want 0", rf_state); end
        in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_fips();
        int acc;
        int n = 0;
        mode = 1'b1; load_key(KEY1);
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fips_idle_ready: got %b want 1", in_ready); end
        in_valid = 1'b1; in_data = PT1; acc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0; in_data = rnd128();
        while (out_valid !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fips_timeout: out_valid got %b want 1", out_valid); end
        n_vec++; if (cyc - acc != 10) begin n_err++; $display("FAIL fips_latency: got %0d want 10", cyc - acc); end
        n_vec++; if (out_data !== CT1) begin n_err++; $display("FAIL fips_ct: got %h want %h", out_data, CT1); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fips_ready_after: got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fips_valid_after: got %b want 0", out_valid); end
    endtask

    task automatic test_identity();
        int nlast = 0;
        mode = 1'b0;
        @(negedge clk);
        n_vec++; if (rk_idx !== 4'd0) begin n_err++; $display("FAIL id_idle_rk_idx: got %0d want 0", rk_idx); end
        in_valid = 1'b1; in_data = IDV;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (rf_last === 1'b1) nlast++;
            n_vec++; if (rk_idx !== 4'(k)) begin n_err++; $display("FAIL id_rk_idx: got %0d want %0d", rk_idx, k); end
            n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL id_busy: got %b want 1 at round %0d", busy, k); end
            n_vec++; if (rf_last !== (k == 10)) begin n_err++; $display("FAIL id_rf_last: got %b want %b at round %0d", rf_last, (k == 10), k); end
        end
        @(negedge clk);
        if (rf_last === 1'b1) nlast++;
        n_vec++; if (nlast != 1) begin n_err++; $display("FAIL id_last_count: got %0d want 1", nlast); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL id_out_valid: got %b want 1", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL id_busy_done: got %b want 0", busy); end
        n_vec++; if (out_data !== IDV) begin n_err++; $display("FAIL id_out_data: got %h want %h", out_data, IDV); end
        n_vec++; if (rf_state !== IDV) begin n_err++; $display("FAIL id_rf_state: got %h want %h", rf_state, IDV); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int n = 0;
        mode = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = IDV2; out_ready = 1'b0;
        @(negedge clk);
        // stray in_valid/out_ready during RUN must not matter
        in_valid = 1'b1; in_data = rnd128(); out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_data = rnd128(); out_ready = 1'b0;
        while (out_valid !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_timeout: out_valid got %b want 1", out_valid); end
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0] ? 1'b0 : 1'b1; in_data = rnd128();
            @(negedge clk);
            n_vec++; if (out_data !== IDV2) begin n_err++; $display("FAIL bp_hold_data: got %h want %h", out_data, IDV2); end
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after: got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_valid_after: got %b want 0", out_valid); end
        n_vec++; if (out_data !== IDV2) begin n_err++; $display("FAIL bp_idle_hold: got %h want %h", out_data, IDV2); end
    endtask

    task automatic test_back_to_back();
        int acc1, acc2 = -1, ov1 = -1, ov2 = -1;
        mode = 1'b1; load_key(KEY1); out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_start_ready: got %b want 1", in_ready); end
        in_valid = 1'b1; in_data = PT1; acc1 = cyc + 1;
        for (int n = 0; n < 60 && ov2 < 0; n++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && ov1 < 0) begin
                ov1 = cyc;
                n_vec++; if (out_data !== CT1) begin n_err++; $display("FAIL b2b_ct1: got %h want %h", out_data, CT1); end
                load_key(KEY2); in_data = PT2;
            end else if (out_valid === 1'b1 && acc2 >= 0 && ov2 < 0) begin
                ov2 = cyc;
                n_vec++; if (out_data !== CT2) begin n_err++; $display("FAIL b2b_ct2: got %h want %h", out_data, CT2); end
                in_valid = 1'b0;
            end
            if (ov1 >= 0 && acc2 < 0 && in_ready === 1'b1 && in_valid === 1'b1) acc2 = cyc + 1;
        end
        in_valid = 1'b0;
        n_vec++; if (ov1 - acc1 != 10) begin n_err++; $display("FAIL b2b_lat1: got %0d want 10", ov1 - acc1); end
        n_vec++; if (acc2 - ov1 != 2) begin n_err++; $display("FAIL b2b_gap: got %0d want 2", acc2 - ov1); end
        n_vec++; if (ov2 - acc2 != 10) begin n_err++; $display("FAIL b2b_lat2: got %0d want 10", ov2 - acc2); end
        @(negedge clk);
        out_ready = 1'b0;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_end_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int seen = 0;
        int acc;
        mode = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = IDV;
        @(negedge clk);
        in_valid = 1'b0;
        while (rk_idx !== 4'd5 && n < 20) begin @(negedge clk); n++; end
        n_vec++; if (rk_idx !== 4'd5 || busy !== 1'b1) begin n_err++; $display("FAIL rm_round5: rk_idx %0d busy %b want 5/1", rk_idx, busy); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rm_in_ready: got %b want 1", in_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b want 0", busy); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
        n_vec++; if (rf_state !== 128'h0) begin n_err++; $display("FAIL rm_state: got %h want 0", rf_state); end
        n_vec++; if (rk_idx !== 4'd0) begin n_err++; $display("FAIL rm_rk_idx: got %0d want 0", rk_idx); end
        repeat (15) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        n_vec++; if (seen != 0) begin n_err++; $display("FAIL rm_ghost_output: got %0d out_valid cycles want 0", seen); end
        // first block after reset runs cleanly
        mode = 1'b1; load_key(KEY1);
        in_valid = 1'b1; in_data = PT1; acc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        n_vec++; if (cyc - acc != 10) begin n_err++; $display("FAIL rm_post_latency: got %0d want 10", cyc - acc); end
        n_vec++; if (out_data !== CT1) begin n_err++; $display("FAIL rm_post_ct: got %h want %h", out_data, CT1); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        build_sbox();
        for (int r = 0; r < 16; r++) rk_tab[r] = 128'h0;
        test_reset();
        test_fips();
        test_identity();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
